// File: rtl/cs_word_pipe.sv
// Registered DEPTH-stage carrier for the microcode control word, from sequencer to datapath.
// Strobe bits fire once per word; held words show IDLE_WORD values on the strobe positions.
module cs_word_pipe #(
    parameter int                  CS_WIDTH    = 64,
    parameter int                  DEPTH       = 1,
    parameter logic [CS_WIDTH-1:0] IDLE_WORD   = 64'h0000_0001_0000_0010,
    parameter logic [CS_WIDTH-1:0] STROBE_MASK = 64'hC1D0_0703_3020_0010,
    parameter int                  HOLD_W      = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CS_WIDTH-1:0] cs_in,
    input  logic                cs_in_valid,
    output logic                cs_in_ready,
    input  logic                stall,
    input  logic                flush,
    output logic [CS_WIDTH-1:0] cs_out,
    output logic                cs_out_valid,
    output logic                cs_out_fire,
    output logic [HOLD_W-1:0]   hold_count
);

    localparam logic [HOLD_W-1:0] HOLD_MAX = {HOLD_W{1'b1}};
    localparam logic [HOLD_W-1:0] HOLD_ONE = {{(HOLD_W-1){1'b0}}, 1'b1};

    generate
        if ((DEPTH < 32'sd1) || (DEPTH > 32'sd4)) begin : g_depth_check
            $fatal(1, "cs_word_pipe: DEPTH must be within 1..4");
        end
    endgenerate

    // Force every strobe position to its inactive (IDLE_WORD) level.
    function automatic logic [CS_WIDTH-1:0] suppress_strobes(input logic [CS_WIDTH-1:0] word);
        return (word & ~STROBE_MASK) | (IDLE_WORD & STROBE_MASK);
    endfunction

    // Saturating increment of the hold counter.
    function automatic logic [HOLD_W-1:0] hold_inc(input logic [HOLD_W-1:0] count);
        return (count == HOLD_MAX) ? HOLD_MAX : (count + HOLD_ONE);
    endfunction

    logic [DEPTH-1:0][CS_WIDTH-1:0] word_r;
    logic [DEPTH-1:0]               valid_r;
    logic [CS_WIDTH-1:0]            cs_out_r;
    logic [HOLD_W-1:0]              hold_count_r;

    logic                           advance_s;
    logic                           accept_s;
    logic [CS_WIDTH-1:0]            stage0_in_s;
    logic [DEPTH-1:0][CS_WIDTH-1:0] word_shift_s;
    logic [DEPTH-1:0]               valid_shift_s;
    logic [DEPTH-1:0]               valid_nxt_s;
    logic [HOLD_W-1:0]              hold_nxt_s;
    logic [CS_WIDTH-1:0]            out_nxt_s;

    assign advance_s   = !stall;
    assign cs_in_ready = !stall && !flush;
    assign accept_s    = cs_in_valid && cs_in_ready;
    // Stage 0 keeps its old word when nothing valid is offered.
    assign stage0_in_s = cs_in_valid ? cs_in : word_r[0];

    generate
        if (DEPTH == 32'sd1) begin : g_shift_single
            assign word_shift_s  = stage0_in_s;
            assign valid_shift_s = accept_s;
        end else begin : g_shift_multi
            assign word_shift_s  = {word_r[DEPTH-2:0], stage0_in_s};
            assign valid_shift_s = {valid_r[DEPTH-2:0], accept_s};
        end
    endgenerate

    // Next-state for valids, hold counter and the registered output word.
    always_comb begin
        valid_nxt_s = valid_r;
        hold_nxt_s  = hold_count_r;
        out_nxt_s   = cs_out_r;
        if (flush) begin
            valid_nxt_s = {DEPTH{1'b0}};
            hold_nxt_s  = {HOLD_W{1'b0}};
            out_nxt_s   = IDLE_WORD;
        end else if (advance_s) begin
            valid_nxt_s = valid_shift_s;
            hold_nxt_s  = {HOLD_W{1'b0}};
            if (valid_shift_s[DEPTH-1]) begin
                out_nxt_s = word_shift_s[DEPTH-1];
            end else begin
                out_nxt_s = IDLE_WORD;
            end
        end else if (valid_r[DEPTH-1]) begin
            // Stalled real word: from the second held cycle on, strobes go inactive.
            hold_nxt_s = hold_inc(hold_count_r);
            out_nxt_s  = suppress_strobes(word_r[DEPTH-1]);
        end else begin
            hold_nxt_s = {HOLD_W{1'b0}};
            out_nxt_s  = IDLE_WORD;
        end
    end

    // Control state and output word, cleared by synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_r      <= {DEPTH{1'b0}};
            hold_count_r <= {HOLD_W{1'b0}};
            cs_out_r     <= IDLE_WORD;
        end else begin
            valid_r      <= valid_nxt_s;
            hold_count_r <= hold_nxt_s;
            cs_out_r     <= out_nxt_s;
        end
    end

    // Word registers need no reset: invalid stages never reach cs_out.
    always_ff @(posedge clock) begin
        if (advance_s) begin
            word_r <= word_shift_s;
        end
    end

    assign cs_out       = cs_out_r;
    assign cs_out_valid = valid_r[DEPTH-1];
    assign cs_out_fire  = valid_r[DEPTH-1] && !stall;
    assign hold_count   = hold_count_r;

endmodule
